hsclk_div_sel: RTL and testbench



---
 rtl/hsclk_div_sel_pkg.sv | 48 ++++
 rtl/hsclk_div_sel_sync_ff.sv | 37 +++
 rtl/hsclk_div_sel.sv | 205 ++++++++++++++++++++
 tb/tb_hsclk_div_sel.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hsclk_div_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hsclk_div_sel_pkg
//  Description : Shared constants for the hsclk divider / HS-select stage:
//                FSM state encoding, divide-ratio lookup and field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package hsclk_div_sel_pkg;

    // Default width of the divider-select field.
    localparam int c_DIV_SEL_W = 2;

    // Width of the period counter and ratio register (largest ratio is 5).
    localparam int c_CNT_W = 3;

    // FSM state encoding.
    localparam logic [1:0] c_ST_OFF   = 2'd0;
    localparam logic [1:0] c_ST_ARM   = 2'd1;
    localparam logic [1:0] c_ST_ON    = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    // Divide ratios selected by cpuclk_div_sel.
    localparam logic [c_CNT_W-1:0] c_RATIO_SEL0 = 3'd2;
    localparam logic [c_CNT_W-1:0] c_RATIO_SEL1 = 3'd3;
    localparam logic [c_CNT_W-1:0] c_RATIO_SEL2 = 3'd4;
    localparam logic [c_CNT_W-1:0] c_RATIO_SEL3 = 3'd5;

    // Map the select code to its divide ratio N.
    function automatic logic [c_CNT_W-1:0] f_ratio(input logic [1:0] sel);
        logic [c_CNT_W-1:0] v_n;
        case (sel)
            2'b00:   v_n = c_RATIO_SEL0;
            2'b01:   v_n = c_RATIO_SEL1;
            2'b10:   v_n = c_RATIO_SEL2;
            default: v_n = c_RATIO_SEL3;
        endcase
        return v_n;
    endfunction

    // First count of the high phase: ceil(N/2). Counts below it are low.
    function automatic logic [c_CNT_W-1:0] f_high_start(input logic [c_CNT_W-1:0] n);
        logic [c_CNT_W-1:0] v_sum;
        v_sum = n + c_CNT_W'(1);
        return v_sum >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsclk_div_sel_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : hsclk_div_sel_sync_ff
//  Description : Multi-flop synchroniser, asynchronously reset to 0. Brings an
//                asynchronous level into the hsclk domain.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset
//                i_d   - asynchronous input level
//                o_q   - synchronised output level
//  Revision    : 1.0 - initial release
// ============================================================================
module hsclk_div_sel_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    // Two flops are the floor for metastability settling.
    localparam int c_DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [c_DEPTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[c_DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_sync[c_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/hsclk_div_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hsclk_div_sel
//  Description : hsclk divider and high-speed clock select handshake. Divides
//                hsclk by 2/3/4/5 and gates the divided clock on and off only
//                at divided-period boundaries, and only while the low-speed
//                path reports that it is parked.
//  Ports       : hsclk          - sole clock, rising edge
//                resetb         - asynchronous active-low reset
//                cpuclk_div_sel - divide ratio select (00:2 01:3 10:4 11:5)
//                hs_req         - async request for the HS clock
//                ls_idle        - async, LS path gated off and parked low
//                hs_clk_out     - registered divided clock, low when disabled
//                hs_selected    - registered, HS clock drives the CPU
//                hs_gate_en     - registered enable to the downstream mux
//                period_end     - pulse on the last cycle of each period
//  Options     : define HSCLK_HOLDOFF_EN to enforce a minimum dwell of
//                HOLDOFF_CYCLES in OFF before re-arming.
//  Revision    : 1.0 - initial release
// ============================================================================
module hsclk_div_sel
    import hsclk_div_sel_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int DIV_SEL_W      = c_DIV_SEL_W
) (
    input  logic                 hsclk,
    input  logic                 resetb,
    input  logic [DIV_SEL_W-1:0] cpuclk_div_sel,
    input  logic                 hs_req,
    input  logic                 ls_idle,
    output logic                 hs_clk_out,
    output logic                 hs_selected,
    output logic                 hs_gate_en,
    output logic                 period_end
);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic w_req_s;
    logic w_idle_s;

    hsclk_div_sel_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk   (hsclk),
        .rst_n (resetb),
        .i_d   (hs_req),
        .o_q   (w_req_s)
    );

    hsclk_div_sel_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_idle (
        .clk   (hsclk),
        .rst_n (resetb),
        .i_d   (ls_idle),
        .o_q   (w_idle_s)
    );

    // ------------------------------------------------------------------
    // Period counter and ratio register
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_ratio;
    logic [c_CNT_W-1:0] w_last;
    logic [c_CNT_W-1:0] w_high_start;
    logic               w_period_end;
    logic               w_phase;

    assign w_last       = r_ratio - c_CNT_W'(1);
    assign w_period_end = (r_count == w_last);
    assign w_high_start = f_high_start(r_ratio);
    assign w_phase      = (r_count >= w_high_start);

    // The ratio is only reloaded on the wrap, so a select change mid-period
    // lets the current period finish at its old length.
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_count <= '0;
            r_ratio <= c_RATIO_SEL0;
        end else if (w_period_end) begin
            r_count <= '0;
            r_ratio <= f_ratio(cpuclk_div_sel[1:0]);
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Select FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_holdoff_done;

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_state <= c_ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ARM and DRAIN only move on period_end, so the gate opens at count 0
    // and closes right after the last (high) count of a period. An ON->DRAIN
    // step taken on period_end costs one extra full period, never a runt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_OFF: begin
                if (w_req_s && w_idle_s && w_holdoff_done) begin
                    w_state_nxt = c_ST_ARM;
                end
            end
            c_ST_ARM: begin
                if (w_period_end) begin
                    w_state_nxt = w_req_s ? c_ST_ON : c_ST_OFF;
                end
            end
            c_ST_ON: begin
                if (!w_req_s) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                // A re-request here is deliberately ignored until OFF.
                if (w_period_end) begin
                    w_state_nxt = c_ST_OFF;
                end
            end
            default: begin
                w_state_nxt = c_ST_OFF;
            end
        endcase
    end

    // Enable is decoded from the next state so the registered copies line
    // up exactly with the state register.
    logic w_en_nxt;

    always_comb begin
        w_en_nxt = 1'b0;
        if ((w_state_nxt == c_ST_ON) || (w_state_nxt == c_ST_DRAIN)) begin
            w_en_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // OFF dwell holdoff
    // ------------------------------------------------------------------
`ifdef HSCLK_HOLDOFF_EN
    localparam int c_HOLD_W = (HOLDOFF_CYCLES < 1) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    logic [c_HOLD_W-1:0] r_holdoff;
    logic                w_off_entry;

    assign w_off_entry = (w_state_nxt == c_ST_OFF) && (r_state != c_ST_OFF);

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_holdoff <= '0;
        end else if (w_off_entry) begin
            r_holdoff <= c_HOLD_W'(HOLDOFF_CYCLES);
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - c_HOLD_W'(1);
        end
    end

    assign w_holdoff_done = (r_holdoff == '0);
`else
    logic [31:0] w_unused_holdoff;

    assign w_unused_holdoff = HOLDOFF_CYCLES;
    assign w_holdoff_done   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic r_gate_en;
    logic r_selected;
    logic r_clk_out;

    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_gate_en  <= 1'b0;
            r_selected <= 1'b0;
            r_clk_out  <= 1'b0;
        end else begin
            r_gate_en  <= w_en_nxt;
            r_selected <= w_en_nxt;
            r_clk_out  <= w_phase & r_gate_en;
        end
    end

    assign hs_clk_out  = r_clk_out;
    assign hs_selected = r_selected;
    assign hs_gate_en  = r_gate_en;
    assign period_end  = w_period_end;

endmodule
`default_nettype wire

// File: tb/tb_hsclk_div_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsclk_div_sel
//  Description : Directed self-checking bench for hsclk_div_sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hsclk_div_sel;

    logic       hsclk;
    logic       resetb;
    logic [1:0] cpuclk_div_sel;
    logic       hs_req;
    logic       ls_idle;
    logic       hs_clk_out;
    logic       hs_selected;
    logic       hs_gate_en;
    logic       period_end;

    int n_total;
    int n_bad;

`ifdef HSCLK_HOLDOFF_EN
    localparam int c_REARM_ON_AT = 15;
`else
    localparam int c_REARM_ON_AT = 10;
`endif

    hsclk_div_sel dut (
        .hsclk          (hsclk),
        .resetb         (resetb),
        .cpuclk_div_sel (cpuclk_div_sel),
        .hs_req         (hs_req),
        .ls_idle        (ls_idle),
        .hs_clk_out     (hs_clk_out),
        .hs_selected    (hs_selected),
        .hs_gate_en     (hs_gate_en),
        .period_end     (period_end)
    );

    initial hsclk = 1'b0;
    always #5 hsclk = ~hsclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick;
        @(posedge hsclk);
        #1;
    endtask

    initial begin
        logic [0:11] e2_clk;
        logic [0:11] e2_pe;
        logic [1:10] e3_clk;
        logic [1:10] e3_pe;
        logic [1:10] e4_clk;
        int          k;

        n_total        = 0;
        n_bad          = 0;
        resetb         = 1'b0;
        cpuclk_div_sel = 2'b00;
        hs_req         = 1'b0;
        ls_idle        = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        chk("rst_clk", hs_clk_out, 0);
        chk("rst_sel", hs_selected, 0);
        chk("rst_gate", hs_gate_en, 0);
        chk("rst_pe", period_end, 0);

        // ---------------- N=2, idle request ----------------
        resetb = 1'b1;
        chk("n2_pe0", period_end, 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("n2_pe", period_end, (i % 2 == 1) ? 1 : 0);
            chk("n2_clk", hs_clk_out, 0);
            chk("n2_sel", hs_selected, 0);
        end

        // ---------------- select HS at N=3 ----------------
        e2_clk = 12'b000000001001;
        e2_pe  = 12'b010010010010;
        cpuclk_div_sel = 2'b01;
        hs_req         = 1'b1;
        ls_idle        = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("n3_sel", hs_selected, (i >= 5) ? 1 : 0);
            chk("n3_clk", hs_clk_out, e2_clk[i]);
            chk("n3_pe", period_end, e2_pe[i]);
        end
        chk("n3_gate", hs_gate_en, 1);

        // ---------------- ratio change 10 -> 11 mid-period ----------------
        cpuclk_div_sel = 2'b10;
        tick(); tick();
        chk("chg_pe_n3", period_end, 1);
        tick();
        chk("chg_b_pe", period_end, 0);
        chk("chg_b_clk", hs_clk_out, 1);
        e3_clk = 10'b0011000110;
        e3_pe  = 10'b0010000100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("chg_clk", hs_clk_out, e3_clk[i]);
            chk("chg_pe", period_end, e3_pe[i]);
            if (i == 1) cpuclk_div_sel = 2'b11;
        end

        // ---------------- drop request mid-period (N=5) ----------------
        e4_clk = 10'b0011000000;
        hs_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("drn_clk", hs_clk_out, e4_clk[i]);
            chk("drn_sel", hs_selected, (i <= 3) ? 1 : 0);
            chk("drn_gate", hs_gate_en, (i <= 3) ? 1 : 0);
            if (i == 3) chk("drn_pe", period_end, 1);
        end

        // ---------------- request with LS not idle ----------------
        hs_req  = 1'b1;
        ls_idle = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("noidle_sel", hs_selected, 0);
        end
        // count is now 1 of a 5-cycle period; ARM must land on count 4
        ls_idle = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("idle_sel", hs_selected, (i == 4) ? 1 : 0);
        end
        chk("idle_gate", hs_gate_en, 1);

        // ---------------- re-request during DRAIN ----------------
        hs_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("rearm_sel", hs_selected, ((i <= 4) || (i >= c_REARM_ON_AT)) ? 1 : 0);
            if (i == 3) hs_req = 1'b1;
        end

        // ---------------- async reset during a high phase ----------------
        k = 0;
        while ((hs_clk_out !== 1'b1) && (k < 20)) begin
            tick();
            k++;
        end
        chk("pre_rst_high", hs_clk_out, 1);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_clk", hs_clk_out, 0);
        chk("arst_sel", hs_selected, 0);
        chk("arst_gate", hs_gate_en, 0);
        chk("arst_pe", period_end, 0);
        #3;
        resetb = 1'b1;
        tick();
        chk("post_rst_pe", period_end, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
